// File: rtl/move_cmd_scheduler.sv
// Block-move command scheduler.
// Key pulses are latched as pending directions. One pending direction is
// granted per frame tick, in round-robin order. The block position is
// updated in step with the frame, and it is clamped to the active area.
module move_cmd_scheduler #(
  parameter int H_ACT  = 800,
  parameter int V_ACT  = 600,
  parameter int BLK_W  = 40,
  parameter int BLK_H  = 40,
  parameter int STEP   = 8,
  parameter int X_INIT = 380,
  parameter int Y_INIT = 280
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_flag1,
  input  logic       key_flag2,
  input  logic       key_flag3,
  input  logic       key_flag4,
  input  logic       frame_sync,
  output logic [9:0] block_x,
  output logic [9:0] block_y,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic       at_edge,
  output logic       busy,
  output logic [3:0] pending
);

  localparam logic [10:0] STEP11 = 11'(STEP);
  localparam logic [10:0] X_LIM  = 11'(H_ACT - BLK_W);
  localparam logic [10:0] Y_LIM  = 11'(V_ACT - BLK_H);

  typedef enum logic [1:0] {IDLE, ARB, APPLY} state_t;

  state_t      state;
  logic [1:0]  rr_ptr;
  logic [1:0]  g;
  logic        fs_meta, fs_sync, fs_prev, frame_tick;
  logic [3:0]  keys;
  logic [1:0]  grant;
  logic        found;
  logic [1:0]  idx;
  logic [3:0]  clr_mask;
  logic [10:0] x_ext, y_ext, nx, ny;
  logic        clamp;

  assign keys  = {key_flag4, key_flag3, key_flag2, key_flag1};
  assign busy  = (state != IDLE);
  assign x_ext = {1'b0, block_x};
  assign y_ext = {1'b0, block_y};

  // Two-flop synchroniser for frame_sync, followed by a registered rising-edge pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fs_meta    <= 1'b0;
      fs_sync    <= 1'b0;
      fs_prev    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      fs_meta    <= frame_sync;
      fs_sync    <= fs_meta;
      fs_prev    <= fs_sync;
      frame_tick <= fs_sync & ~fs_prev;
    end
  end

  // Round-robin pick: the first pending bit found when scanning up from rr_ptr.
  always_comb begin
    grant = rr_ptr;
    found = 1'b0;
    idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = rr_ptr + 2'(i);
      if (!found && pending[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  // Compute the clamped next position for the latched grant.
  // clamp marks that the edge branch was taken.
  always_comb begin
    nx    = x_ext;
    ny    = y_ext;
    clamp = 1'b0;
    case (g)
      2'd0: if (y_ext < STEP11) begin ny = 11'd0; clamp = 1'b1; end
            else ny = y_ext - STEP11;
      2'd1: if (y_ext + STEP11 > Y_LIM) begin ny = Y_LIM; clamp = 1'b1; end
            else ny = y_ext + STEP11;
      2'd2: if (x_ext < STEP11) begin nx = 11'd0; clamp = 1'b1; end
            else nx = x_ext - STEP11;
      default: if (x_ext + STEP11 > X_LIM) begin nx = X_LIM; clamp = 1'b1; end
            else nx = x_ext + STEP11;
    endcase
  end

  // The serviced bit is cleared only in APPLY.
  // A key pulse in the same cycle overrides the clear.
  always_comb begin
    clr_mask = 4'b0000;
    if (state == APPLY) clr_mask[g] = 1'b1;
  end

  // Pending latch, control FSM and registered position outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      pending    <= 4'b0000;
      rr_ptr     <= 2'd0;
      g          <= 2'd0;
      block_x    <= 10'(X_INIT);
      block_y    <= 10'(Y_INIT);
      move_valid <= 1'b0;
      move_dir   <= 2'd0;
      at_edge    <= 1'b0;
    end else begin
      pending    <= (pending & ~clr_mask) | keys;
      move_valid <= 1'b0;
      case (state)
        IDLE:  if (frame_tick && pending != 4'b0000) state <= ARB;
        ARB: begin
          g     <= grant;
          state <= APPLY;
        end
        APPLY: begin
          block_x    <= nx[9:0];
          block_y    <= ny[9:0];
          move_valid <= 1'b1;
          move_dir   <= g;
          at_edge    <= clamp;
          rr_ptr     <= g + 2'd1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_cmd_scheduler.sv
// Directed bench for move_cmd_scheduler.
// It uses a table of single-frame vectors, plus hand sequences for clamping,
// collapsed presses, set-wins behaviour and reset during APPLY.
module tb_move_cmd_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] keys = 4'b0000;
  logic       frame_sync = 1'b0;
  logic [9:0] block_x, block_y;
  logic       move_valid, at_edge, busy;
  logic [1:0] move_dir;
  logic [3:0] pending;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  move_cmd_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .key_flag1(keys[0]), .key_flag2(keys[1]), .key_flag3(keys[2]), .key_flag4(keys[3]),
    .frame_sync(frame_sync),
    .block_x(block_x), .block_y(block_y),
    .move_valid(move_valid), .move_dir(move_dir), .at_edge(at_edge),
    .busy(busy), .pending(pending)
  );

  typedef struct {
    logic [3:0] keys;
    int mv;
    int x;
    int y;
    int dir;
    int edg;
    int pend;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_keys(input logic [3:0] k);
    @(negedge clk) keys = k;
    @(negedge clk) keys = 4'b0000;
  endtask

  // Raise frame_sync and observe 12 cycles, sampling on negedges.
  // Optionally inject keys or assert reset at a given cycle after the rise.
  task automatic do_frame(input logic [3:0] inj_keys, input int inj_at, input int rst_at,
                          output int mv_cnt, output int mv_cyc, output int busy_seen);
    mv_cnt = 0; mv_cyc = -1; busy_seen = 0;
    @(negedge clk) frame_sync = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (move_valid) begin mv_cnt++; mv_cyc = k; end
      if (busy) busy_seen = 1;
      if (k == inj_at) keys = inj_keys;
      else if (k == inj_at + 1) keys = 4'b0000;
      if (k == rst_at) rst_n = 1'b0;
      else if (k == rst_at + 2) rst_n = 1'b1;
      if (k == 8) frame_sync = 1'b0;
    end
  endtask

  task automatic check_pos(input string tag, input int x, input int y, input int dir,
                           input int edg, input int pend);
    check({tag, ".x"}, int'(block_x), x);
    check({tag, ".y"}, int'(block_y), y);
    check({tag, ".dir"}, int'(move_dir), dir);
    check({tag, ".edge"}, int'(at_edge), edg);
    check({tag, ".pend"}, int'(pending), pend);
  endtask

  initial begin
    int cnt, cyc, bsy, mv_during_rst;

    vecs[0] = '{4'b1000, 1, 388, 280, 3, 0, 4'b0000};
    vecs[1] = '{4'b0111, 1, 388, 272, 0, 0, 4'b0110};
    vecs[2] = '{4'b0000, 1, 388, 280, 1, 0, 4'b0100};
    vecs[3] = '{4'b0000, 1, 380, 280, 2, 0, 4'b0000};
    vecs[4] = '{4'b0000, 0, 380, 280, 2, 0, 4'b0000};

    // Reset held with keys active
    mv_during_rst = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk) keys = 4'b1111;
      if (move_valid) mv_during_rst++;
    end
    @(negedge clk) begin keys = 4'b0000; rst_n = 1'b1; end
    if (move_valid) mv_during_rst++;
    check("rst.mv", mv_during_rst, 0);
    check_pos("rst", 380, 280, 0, 0, 0);
    check("rst.busy", int'(busy), 0);

    // Table-driven single-frame vectors
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].keys != 4'b0000) pulse_keys(vecs[v].keys);
      do_frame(4'b0000, -10, -10, cnt, cyc, bsy);
      check($sformatf("vec%0d.mvcnt", v), cnt, vecs[v].mv);
      if (vecs[v].mv != 0) check($sformatf("vec%0d.lat", v), cyc, 6);
      else check($sformatf("vec%0d.busy", v), bsy, 0);
      check_pos($sformatf("vec%0d", v), vecs[v].x, vecs[v].y, vecs[v].dir,
                vecs[v].edg, vecs[v].pend);
      check($sformatf("vec%0d.busyend", v), int'(busy), 0);
    end

    // Move up to the top edge, then once more for a clamped move
    for (int i = 0; i < 35; i++) begin
      pulse_keys(4'b0001);
      do_frame(4'b0000, -10, -10, cnt, cyc, bsy);
    end
    check_pos("top", 380, 0, 0, 0, 0);
    pulse_keys(4'b0001);
    do_frame(4'b0000, -10, -10, cnt, cyc, bsy);
    check("topclamp.mv", cnt, 1);
    check_pos("topclamp", 380, 0, 0, 1, 0);

    // Move right to 756, then clamp to 760 twice
    for (int i = 0; i < 47; i++) begin
      pulse_keys(4'b1000);
      do_frame(4'b0000, -10, -10, cnt, cyc, bsy);
    end
    check_pos("r756", 756, 0, 3, 0, 0);
    pulse_keys(4'b1000);
    do_frame(4'b0000, -10, -10, cnt, cyc, bsy);
    check("rclamp1.mv", cnt, 1);
    check_pos("rclamp1", 760, 0, 3, 1, 0);
    pulse_keys(4'b1000);
    do_frame(4'b0000, -10, -10, cnt, cyc, bsy);
    check("rclamp2.mv", cnt, 1);
    check_pos("rclamp2", 760, 0, 3, 1, 0);

    // Five left presses collapse into one move
    for (int i = 0; i < 5; i++) pulse_keys(4'b0100);
    check("collapse.pend", int'(pending), 4'b0100);
    do_frame(4'b0000, -10, -10, cnt, cyc, bsy);
    check("collapse.mv", cnt, 1);
    check_pos("collapse", 752, 0, 2, 0, 0);
    do_frame(4'b0000, -10, -10, cnt, cyc, bsy);
    check("collapse2.mv", cnt, 0);

    // A right press during APPLY of a right grant keeps the pending bit set
    pulse_keys(4'b1000);
    do_frame(4'b1000, 5, -10, cnt, cyc, bsy);
    check("setwins.mv", cnt, 1);
    check_pos("setwins", 760, 0, 3, 0, 4'b1000);
    do_frame(4'b0000, -10, -10, cnt, cyc, bsy);
    check("setwins2.mv", cnt, 1);
    check_pos("setwins2", 760, 0, 3, 1, 0);

    // A tick with nothing pending does nothing
    do_frame(4'b0000, -10, -10, cnt, cyc, bsy);
    check("idle.mv", cnt, 0);
    check("idle.busy", bsy, 0);
    check_pos("idle", 760, 0, 3, 1, 0);

    // Reset asserted in the APPLY cycle
    pulse_keys(4'b0100);
    do_frame(4'b0000, -10, 5, cnt, cyc, bsy);
    check("rstapply.mv", cnt, 0);
    check_pos("rstapply", 380, 280, 0, 0, 0);
    check("rstapply.busy", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/move_cmd_scheduler.md
Name: move_cmd_scheduler

Overview:
Sequences block-movement commands from the four debounced key pulses into the on-screen block position consumed by the pixel renderer. Each key press is latched as a pending direction, and pending directions are round-robin arbitrated. At most one move is applied per video frame, timed to the vertical sync so position never changes mid-frame. Position is clamped to the 800x600 active area; sits between key_filter instances and the renderer in the CLOCK_50 domain.

Parameters:
H_ACT, 800, active pixels per line
V_ACT, 600, active lines per frame
BLK_W, 40, block width in pixels
BLK_H, 40, block height in pixels
STEP, 8, pixels moved per granted command (1..BLK_W)
X_INIT, 380, reset x of block top-left
Y_INIT, 280, reset y of block top-left

Ports:
clk  in  1  system clock (CLOCK_50 domain)
rst_n  in  1  synchronous active-low reset
key_flag1  in  1  one-cycle pulse: up
key_flag2  in  1  one-cycle pulse: down
key_flag3  in  1  one-cycle pulse: left
key_flag4  in  1  one-cycle pulse: right
frame_sync  in  1  vertical sync from VGA clock domain, asynchronous to clk
block_x  out  10  block top-left x, 0..H_ACT-BLK_W
block_y  out  10  block top-left y, 0..V_ACT-BLK_H
move_valid  out  1  one-cycle pulse: a move was applied this cycle
move_dir  out  2  direction of last applied move: 0 up, 1 down, 2 left, 3 right
at_edge  out  1  last applied move was clamped (position changed by less than STEP)
busy  out  1  FSM not in IDLE
pending  out  4  latched, unserviced directions (bit0 up .. bit3 right)

Behaviour:
- Clocking and reset: single clock; all registers reset synchronously when rst_n=0 at the clk edge.
- Reset values: block_x=X_INIT, block_y=Y_INIT, move_valid=0, move_dir=0, at_edge=0, busy=0, pending=0, rr_ptr=0, state=IDLE.
- Reset mid-operation discards pending commands and any in-flight grant.
- frame_sync handling: 2-FF synchroniser, then a registered rising-edge detector producing frame_tick. frame_tick is high 3 clk after the frame_sync rise and lasts exactly 1 cycle.
- Pending latch:
  - key_flagN=1 sets pending[N-1].
  - Clearing a bit at APPLY: if the same key pulses in that same cycle, set wins and the bit stays 1.
  - Repeated presses of one direction before service collapse into one command.
  - Simultaneous pulses on several keys set all the corresponding bits.
- FSM states IDLE, ARB, APPLY:
  - IDLE: frame_tick=1 and pending!=0 -> ARB. Otherwise stay in IDLE; a tick with pending==0 is a no-op.
  - ARB: grant = first set bit of pending, scanning from rr_ptr upward modulo 4. Latch grant into g. -> APPLY.
  - APPLY: update position, pulse move_valid=1, set move_dir=g, clear pending[g], rr_ptr<=(g+1) mod 4. -> IDLE.
  - frame_tick arriving while in ARB or APPLY is ignored.
- Rate: at most one move per frame_tick.
- Latency: frame_tick in cycle N -> ARB in N+1 -> APPLY in N+2 -> new block_x/y, move_valid, move_dir and at_edge visible in N+3.
- Arithmetic: 11-bit intermediates; limits X_LIM=H_ACT-BLK_W, Y_LIM=V_ACT-BLK_H.
  - up: y<STEP ? 0 : y-STEP
  - down: y+STEP>Y_LIM ? Y_LIM : y+STEP
  - left: x<STEP ? 0 : x-STEP
  - right: x+STEP>X_LIM ? X_LIM : x+STEP
  - No wrap-around at any edge.
  - at_edge=1 when the clamp branch was taken. A move at an edge still pulses move_valid, with zero displacement.
  - at_edge and move_dir hold until the next APPLY.
- busy = (state != IDLE).
- pending output is the live pending register.

Test Plan:
- Reset: hold rst_n=0 for 2 clk with keys pulsing -> block_x=380, block_y=280, pending=0, busy=0, move_valid never asserted.
- Single right press then one frame_sync rise -> move_valid pulses exactly once, 6 clk after the rise (3 sync/edge + 3 FSM); block_x=388, move_dir=3, at_edge=0, pending=0.
- Up, down and left pulsed in the same cycle, then 3 frame ticks from rr_ptr=0 -> grants in order up, down, left. Net result y=280, x=372; one move_valid per frame.
- Clamp: start at y=4, press up, tick -> block_y=0, at_edge=1. Press up again, tick -> block_y=0, at_edge=1, move_valid still pulses. Drive x to 760 via right presses -> further right gives x=760 with at_edge=1.
- Collapse and set-wins:
  - 5 right pulses before one tick -> one move only (x +8).
  - A right pulse in the APPLY cycle of a right grant -> pending[3] remains 1, and the next tick moves right again.
- Tick with pending=0 -> no state change, busy stays 0. Reset asserted in the APPLY cycle -> position returns to X_INIT/Y_INIT and no move_valid is seen.
